serial_add_seq: RTL and testbench
=================================

# serial_add_seq

Bit-serial operand sequencer that sits directly upstream of the `fulladd` stage and closes the loop around it.

- Accepts two WIDTH-bit operands plus carry-in over a valid/ready handshake.
- Feeds `fulladd` one bit position per transaction, using a one-cycle `sample` pulse and the `done` rising edge.
- Chains `cout` back as the next `cin` and assembles the WIDTH-bit sum.
- Presents the result downstream over a second valid/ready handshake.

## Interface

Parameters:
- WIDTH, 8, operand/result width in bits (≥2)
- TIMEOUT, 15, max cycles spent waiting for a `done` rising edge per bit (≥1)

Ports:
- clk  in  1  clock, all logic on posedge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  operands offered
- in_ready  out  1  block can accept operands
- op_a  in  WIDTH  operand A
- op_b  in  WIDTH  operand B
- op_cin  in  1  initial carry-in
- fa_a  out  1  bit to fulladd `a`
- fa_b  out  1  bit to fulladd `b`
- fa_cin  out  1  carry to fulladd `cin`
- fa_sample  out  1  one-cycle sample pulse to fulladd
- fa_sum  in  1  fulladd `sum`
- fa_cout  in  1  fulladd `cout`
- fa_done  in  1  fulladd `done`
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts result
- out_sum  out  WIDTH  assembled sum
- out_cout  out  1  final carry
- out_err  out  1  result aborted by timeout

## Operation

- **FSM states:** IDLE, ISSUE, WAIT, OUT.
- **IDLE:**
  - in_ready=1.
  - On in_valid: latch op_a/op_b, carry←op_cin, idx←0, result←0, go to ISSUE.
- **ISSUE (exactly one cycle):**
  - fa_sample=1.
  - fa_a=a_reg[idx], fa_b=b_reg[idx], fa_cin=carry; these are registered and loaded on entry to ISSUE.
  - Go to WAIT and clear the timeout counter.
- **WAIT:**
  - fa_sample=0; fa_a/fa_b/fa_cin held stable.
  - Rise detect: fa_done=1 and done_q=0, where done_q is fa_done delayed one cycle.
    - On rise: result[idx]←fa_sum, carry←fa_cout.
    - If idx==WIDTH-1, go to OUT; else idx++ and go to ISSUE.
  - Else, if the counter reaches TIMEOUT, go to OUT with err←1. Bits already captured are kept; higher bits stay 0. out_cout = current carry.
  - Else the counter increments.
- **OUT:**
  - out_valid=1; out_sum, out_cout and out_err stay stable until out_valid && out_ready.
  - Then go to IDLE and clear err.
- **Rules for fa_done:**
  - A fa_done that stays high across bits produces no new edge, so that bit ends in timeout.
  - fa_done edges outside WAIT are ignored.
- **Arithmetic:** {out_cout, out_sum} = op_a + op_b + op_cin, modulo 2^(WIDTH+1).
- **in_ready:** 0 in ISSUE, WAIT and OUT. At most one operation is in flight.

## Timing

- **Reset values** (on the edge where rst_n=0):
  - state=IDLE, in_ready=1.
  - fa_a, fa_b, fa_cin, fa_sample = 0.
  - out_valid, out_sum, out_cout, out_err = 0.
  - done_q, idx, counter = 0.
- **Reset mid-operation:** drops the operation. No out_valid is produced, and fa_sample is 0 from the next cycle.
- **Accept:** handshake at edge k puts ISSUE (fa_sample=1) in cycle k+1.
- **Per-bit period:** L+1 cycles, where L is the number of cycles from the fa_sample cycle to the cycle in which the fa_done rise is observed. fa_sample is therefore low for at least one cycle between pulses.
- **Result:** out_valid is first high in cycle k+1+WIDTH·(L+1).
- **Back-to-back:** an out_valid&&out_ready edge returns to IDLE. The next accept can occur one cycle later.
- **Simultaneous events in WAIT:** a rise on the same cycle the counter hits TIMEOUT counts as success.

## Structure

- **serial_add_pkg:**
  - state typedef enum (IDLE, ISSUE, WAIT, OUT).
  - Default WIDTH/TIMEOUT localparams.
  - Function `cnt_w(TIMEOUT)` = $clog2(TIMEOUT+1).
- **Sub-module `rise_det`:** registers fa_done and outputs the one-cycle rise pulse; clk and rst_n are the same as the parent.
- **Top:** FSM, operand and result shift/index registers, timeout counter.

## Test plan

The bench drives the real `fulladd` (or a model with L=2) and checks each result against a reference sum.

- a=0x5A, b=0x33, cin=0 → out_sum=0x8D, out_cout=0, out_err=0; out_valid in cycle k+25.
- a=0xFF, b=0x01, cin=0 → out_sum=0x00, out_cout=1; the carry propagates through all 8 bits (fa_cin=1 for bits 1–7).
- a=0xFF, b=0xFF, cin=1 → out_sum=0xFF, out_cout=1; exactly 8 fa_sample pulses, each one cycle wide and separated by ≥1 low cycle.
- out_ready held low for 5 cycles after out_valid → outputs stable, in_ready=0, no fa_sample, and a concurrent in_valid is not accepted. Then out_ready=1 → IDLE.
- Model suppresses done for bit 3 of a=0x0F, b=0x00 → out_err=1 exactly TIMEOUT cycles after entering WAIT, out_sum=0x07, out_cout=0.
- rst_n=0 for one cycle during bit 4 → next cycle all outputs at their reset values and no out_valid. A following a=0x01, b=0x01 → 0x02, cout=0.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared state encoding, default sizing and counter-width helper for the
// bit-serial adder sequencer.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } state_t;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_TIMEOUT = 15;

  // Bits needed for a counter that must be able to hold the value TIMEOUT.
  function automatic int cnt_w(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/serial_add_seq_rise_det.sv
// One-cycle rising-edge detector for the fulladd done strobe; the pulse is
// high in the cycle where done is 1 and was 0 the cycle before.
module rise_det (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_done,
  output logic o_rise
);

  logic r_done_q;

  // Delay done by one cycle to compare against its previous value.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_done_q <= 1'b0;
    end else begin
      r_done_q <= i_done;
    end
  end

  assign o_rise = i_done & ~r_done_q;

endmodule

// File: rtl/serial_add_seq.sv
// Bit-serial operand sequencer: feeds fulladd one bit per transaction,
// chains the carry back and returns the assembled sum over valid/ready.
module serial_add_seq
  import serial_add_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_op_a,
  input  logic [WIDTH-1:0] i_op_b,
  input  logic             i_op_cin,
  output logic             o_fa_a,
  output logic             o_fa_b,
  output logic             o_fa_cin,
  output logic             o_fa_sample,
  input  logic             i_fa_sum,
  input  logic             i_fa_cout,
  input  logic             i_fa_done,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out_sum,
  output logic             o_out_cout,
  output logic             o_out_err
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam int CNT_W = cnt_w(TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

  state_t             r_state;
  state_t             w_next_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_result;
  logic [WIDTH-1:0]   w_result_nxt;
  logic               r_carry;
  logic [IDX_W-1:0]   r_idx;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               w_rise;
  logic               w_last;
  logic               w_timeout;

  logic               r_in_ready;
  logic               r_fa_a;
  logic               r_fa_b;
  logic               r_fa_cin;
  logic               r_fa_sample;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_out_sum;
  logic               r_out_cout;
  logic               r_out_err;

  rise_det u_rise_det (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_done  (i_fa_done),
    .o_rise  (w_rise)
  );

  assign w_last    = (r_idx == LAST_IDX);
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  // The wait ends after TIMEOUT cycles in WAIT; a rise in that last cycle still wins.
  assign w_timeout = (w_cnt_inc == CNT_MAX);

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (i_in_valid) begin
          w_next_state = ISSUE;
        end else begin
          w_next_state = IDLE;
        end
      end
      ISSUE: begin
        w_next_state = WAIT;
      end
      WAIT: begin
        if (w_rise) begin
          if (w_last) begin
            w_next_state = OUT;
          end else begin
            w_next_state = ISSUE;
          end
        end else if (w_timeout) begin
          w_next_state = OUT;
        end else begin
          w_next_state = WAIT;
        end
      end
      OUT: begin
        if (i_out_ready) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = OUT;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Result with the current bit merged in when fulladd reports completion.
  always_comb begin
    w_result_nxt = r_result;
    if ((r_state == WAIT) && w_rise) begin
      w_result_nxt[r_idx] = i_fa_sum;
    end else begin
      w_result_nxt = r_result;
    end
  end

  // Operand shifting, bit issue, result capture and output registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_a         <= '0;
      r_b         <= '0;
      r_result    <= '0;
      r_carry     <= 1'b0;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_fa_a      <= 1'b0;
      r_fa_b      <= 1'b0;
      r_fa_cin    <= 1'b0;
      r_fa_sample <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_cout  <= 1'b0;
      r_out_err   <= 1'b0;
    end else begin
      r_in_ready  <= (w_next_state == IDLE);
      r_fa_sample <= (w_next_state == ISSUE);
      r_out_valid <= (w_next_state == OUT);
      case (r_state)
        IDLE: begin
          if (i_in_valid) begin
            r_a      <= i_op_a;
            r_b      <= i_op_b;
            r_carry  <= i_op_cin;
            r_idx    <= '0;
            r_result <= '0;
            r_fa_a   <= i_op_a[0];
            r_fa_b   <= i_op_b[0];
            r_fa_cin <= i_op_cin;
          end
        end
        ISSUE: begin
          r_cnt <= '0;
        end
        WAIT: begin
          if (w_rise) begin
            r_result <= w_result_nxt;
            r_carry  <= i_fa_cout;
            if (w_last) begin
              r_out_sum  <= w_result_nxt;
              r_out_cout <= i_fa_cout;
              r_out_err  <= 1'b0;
            end else begin
              // r_a[0]/r_b[0] are the bits just consumed; bit 1 is next.
              r_idx    <= r_idx + IDX_W'(1);
              r_a      <= r_a >> 1;
              r_b      <= r_b >> 1;
              r_fa_a   <= r_a[1];
              r_fa_b   <= r_b[1];
              r_fa_cin <= i_fa_cout;
            end
          end else if (w_timeout) begin
            r_cnt      <= w_cnt_inc;
            r_out_sum  <= r_result;
            r_out_cout <= r_carry;
            r_out_err  <= 1'b1;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        OUT: begin
          if (i_out_ready) begin
            r_out_err <= 1'b0;
          end
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_fa_a      = r_fa_a;
  assign o_fa_b      = r_fa_b;
  assign o_fa_cin    = r_fa_cin;
  assign o_fa_sample = r_fa_sample;
  assign o_out_valid = r_out_valid;
  assign o_out_sum   = r_out_sum;
  assign o_out_cout  = r_out_cout;
  assign o_out_err   = r_out_err;

endmodule

// File: tb/tb_serial_add_seq.sv
// Directed bench for serial_add_seq with a fulladd model answering each
// sample pulse two cycles later (L=2); an optional bit can be left unanswered.
module tb_serial_add_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       op_cin;
  logic       fa_a, fa_b, fa_cin, fa_sample;
  logic       fa_sum, fa_cout, fa_done;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_sum;
  logic       out_cout;
  logic       out_err;

  int n_cmp = 0;
  int n_bad = 0;

  // fulladd model state
  int         m_supp = -1;
  int         m_stage = 0;
  int         m_bit = 0;
  int         m_pend_bit = 0;
  logic [7:0] m_cin_log = 8'h00;
  int         shape_err = 0;
  logic       prev_sample = 1'b0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    int         supp;
    logic [7:0] e_sum;
    logic       e_cout;
    logic       e_err;
    int         e_lat;
    logic [7:0] e_cin;
    int         e_pulses;
  } vec_t;

  vec_t vecs[12];

  serial_add_seq #(.WIDTH(8), .TIMEOUT(15)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_op_a      (op_a),
    .i_op_b      (op_b),
    .i_op_cin    (op_cin),
    .o_fa_a      (fa_a),
    .o_fa_b      (fa_b),
    .o_fa_cin    (fa_cin),
    .o_fa_sample (fa_sample),
    .i_fa_sum    (fa_sum),
    .i_fa_cout   (fa_cout),
    .i_fa_done   (fa_done),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_sum   (out_sum),
    .o_out_cout  (out_cout),
    .o_out_err   (out_err)
  );

  always #5 clk = ~clk;

  // fulladd model: done rises two cycles after the sample cycle, for one cycle.
  initial begin
    fa_sum  = 1'b0;
    fa_cout = 1'b0;
    fa_done = 1'b0;
    forever begin
      @(negedge clk);
      fa_done = 1'b0;
      if (in_ready) begin
        m_stage   = 0;
        m_bit     = 0;
        m_cin_log = 8'h00;
      end else begin
        if (m_stage == 2) begin
          if (m_pend_bit != m_supp) fa_done = 1'b1;
          m_stage = 0;
        end else if (m_stage == 1) begin
          m_stage = 2;
        end
        if (fa_sample) begin
          {fa_cout, fa_sum} = 2'(fa_a) + 2'(fa_b) + 2'(fa_cin);
          if (m_bit < 8) m_cin_log[m_bit] = fa_cin;
          m_pend_bit = m_bit;
          m_bit      = m_bit + 1;
          m_stage    = 1;
        end
      end
    end
  end

  // Sample pulses must be one cycle wide with a low cycle between them.
  initial begin
    forever begin
      @(negedge clk);
      if (fa_sample && prev_sample) shape_err = shape_err + 1;
      prev_sample = fa_sample;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Called at a negedge with in_ready high; returns at the first out_valid cycle.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic c, output int lat);
    in_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    op_cin   = c;
    @(negedge clk);
    in_valid = 1'b0;
    chk("issue_after_accept", fa_sample, 1);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat = lat + 1;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("release_valid_low", out_valid, 0);
    chk("release_in_ready", in_ready, 1);
  endtask

  initial begin
    int lat;
    int quiet;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    op_a      = 8'h00;
    op_b      = 8'h00;
    op_cin    = 1'b0;
    out_ready = 1'b0;

    vecs[0]  = '{8'h5A, 8'h33, 1'b0, -1, 8'h8D, 1'b0, 1'b0, 25, 8'hE4, 8};
    vecs[1]  = '{8'hFF, 8'h01, 1'b0, -1, 8'h00, 1'b1, 1'b0, 25, 8'hFE, 8};
    vecs[2]  = '{8'hFF, 8'hFF, 1'b1, -1, 8'hFF, 1'b1, 1'b0, 25, 8'hFF, 8};
    vecs[3]  = '{8'h00, 8'h00, 1'b0, -1, 8'h00, 1'b0, 1'b0, 25, 8'h00, 8};
    vecs[4]  = '{8'h00, 8'h00, 1'b1, -1, 8'h01, 1'b0, 1'b0, 25, 8'h01, 8};
    vecs[5]  = '{8'h80, 8'h80, 1'b0, -1, 8'h00, 1'b1, 1'b0, 25, 8'h00, 8};
    vecs[6]  = '{8'hA5, 8'h5A, 1'b1, -1, 8'h00, 1'b1, 1'b0, 25, 8'hFF, 8};
    vecs[7]  = '{8'h12, 8'h34, 1'b0, -1, 8'h46, 1'b0, 1'b0, 25, 8'h60, 8};
    vecs[8]  = '{8'h0F, 8'h00, 1'b0,  3, 8'h07, 1'b0, 1'b1, 26, 8'h00, 4};
    vecs[9]  = '{8'hFF, 8'hFF, 1'b0,  0, 8'h00, 1'b0, 1'b1, 17, 8'h00, 1};
    vecs[10] = '{8'hFF, 8'h01, 1'b0,  7, 8'h00, 1'b1, 1'b1, 38, 8'hFE, 8};
    vecs[11] = '{8'h01, 8'h7F, 1'b0, -1, 8'h80, 1'b0, 1'b0, 25, 8'hFE, 8};

    repeat (3) @(negedge clk);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_fa_bits", {fa_a, fa_b, fa_cin, fa_sample}, 0);
    chk("reset_out", {out_valid, out_cout, out_err, out_sum}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Downstream stall: outputs hold, no new accept, no sample pulses.
    do_op(8'hC3, 8'h3C, 1'b0, lat);
    chk("stall_latency", lat, 25);
    in_valid = 1'b1;
    op_a     = 8'h11;
    op_b     = 8'h22;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", out_valid, 1);
      chk("stall_sum", {out_cout, out_err, out_sum}, {2'b00, 8'hFF});
      chk("stall_in_ready", in_ready, 0);
      chk("stall_no_sample", fa_sample, 0);
    end
    in_valid = 1'b0;
    release_out();

    for (int v = 0; v < 12; v++) begin
      m_supp = vecs[v].supp;
      do_op(vecs[v].a, vecs[v].b, vecs[v].cin, lat);
      chk($sformatf("v%0d_latency", v), lat, vecs[v].e_lat);
      chk($sformatf("v%0d_sum", v), out_sum, vecs[v].e_sum);
      chk($sformatf("v%0d_cout", v), out_cout, vecs[v].e_cout);
      chk($sformatf("v%0d_err", v), out_err, vecs[v].e_err);
      chk($sformatf("v%0d_cin_chain", v), m_cin_log, vecs[v].e_cin);
      chk($sformatf("v%0d_pulses", v), m_bit, vecs[v].e_pulses);
      chk($sformatf("v%0d_sample_shape", v), shape_err, 0);
      release_out();
    end
    m_supp = -1;

    // Reset for one cycle while bit 4 is in flight.
    in_valid = 1'b1;
    op_a     = 8'hAA;
    op_b     = 8'h55;
    op_cin   = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (12) @(negedge clk);
    chk("bit4_issue", fa_sample, 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midreset_in_ready", in_ready, 1);
    chk("midreset_fa_bits", {fa_a, fa_b, fa_cin, fa_sample}, 0);
    chk("midreset_out", {out_valid, out_cout, out_err, out_sum}, 0);
    quiet = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid || fa_sample || !in_ready) quiet = quiet + 1;
    end
    chk("midreset_quiet", quiet, 0);

    do_op(8'h01, 8'h01, 1'b0, lat);
    chk("post_reset_latency", lat, 25);
    chk("post_reset_sum", out_sum, 8'h02);
    chk("post_reset_cout", out_cout, 0);
    chk("post_reset_err", out_err, 0);
    release_out();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
